led_scan_mux: RTL and testbench

- Time-multiplexed driver for a common-anode 7-segment display bank.
- Accepts a packed word of hex digits plus per-digit decimal-point and blank masks from the processor side.
- Decodes each digit to segments on-chip, using the team's standard hex-to-segment pattern, and scans one anode at a time.
- Sits between the MMIO register slice and the board pins. Double-buffered so updates never tear mid-frame.

---
 rtl/led_scan_mux.sv | 152 +++++++++++++++
 tb/tb_led_scan_mux.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_mux.sv
// -----------------------------------------------------------------------------
// led_scan_mux
//   Time-multiplexed driver for a common-anode 7-segment display bank.
//   The processor writes digit values, decimal points and blank masks into a
//   shadow copy. The shadow is promoted to the active copy only when the scan
//   wraps back to digit 0, so a frame never shows a mix of old and new data.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   wr          one-cycle strobe: capture hex_in/dp_in/blank_in into shadow
//   hex_in      packed hex digits, nibble i -> digit i (digit 0 rightmost)
//   dp_in       decimal point per digit, 1 = lit
//   blank_in    forced blank per digit, 1 = segments off
//   lz_en       leading-zero blanking enable (level, sampled live)
//   an          anode enables, active-low
//   sseg        {dp,g,f,e,d,c,b,a}, active-low
//   pending     shadow holds data not yet committed to the display
//   frame_tick  one-cycle pulse after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module led_scan_mux #(
    parameter int N_DIGIT  = 8,
    parameter int PRESCALE = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [4*N_DIGIT-1:0] hex_in,
    input  logic [N_DIGIT-1:0]   dp_in,
    input  logic [N_DIGIT-1:0]   blank_in,
    input  logic                 lz_en,
    output logic [N_DIGIT-1:0]   an,
    output logic [7:0]           sseg,
    output logic                 pending,
    output logic                 frame_tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(N_DIGIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGIT - 1);

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*N_DIGIT-1:0]   sh_hex_q, sh_hex_d, act_hex_q, act_hex_d;
    logic [N_DIGIT-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [N_DIGIT-1:0]     sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic                   pending_q, pending_d;
    logic [N_DIGIT-1:0]     an_q, an_d;
    logic [7:0]             sseg_q, sseg_d;
    logic                   frame_tick_q, frame_tick_d;

    logic                   cnt_tc, wrap, commit, zero_run;
    logic [N_DIGIT-1:0]     lz_blank;

    always_comb begin
        cnt_tc = (cnt_q == CNT_LAST);
        wrap   = cnt_tc && (idx_q == IDX_LAST);
        commit = wrap && pending_q;

        cnt_d = cnt_tc ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        // Commit takes the shadow as it stood before this edge, so a write on
        // the same edge lands in the shadow and keeps pending set.
        act_hex_d   = commit ? sh_hex_q   : act_hex_q;
        act_dp_d    = commit ? sh_dp_q    : act_dp_q;
        act_blank_d = commit ? sh_blank_q : act_blank_q;

        sh_hex_d   = wr ? hex_in   : sh_hex_q;
        sh_dp_d    = wr ? dp_in    : sh_dp_q;
        sh_blank_d = wr ? blank_in : sh_blank_q;
        pending_d  = wr ? 1'b1 : (commit ? 1'b0 : pending_q);

        frame_tick_d = wrap;

        // Walk from the most significant digit down; a digit is a leading
        // zero while every nibble from it upward is zero. Digit 0 always shows.
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = N_DIGIT - 1; i >= 0; i--) begin
            zero_run    = zero_run && (act_hex_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_en && (i != 0) && zero_run;
        end

        // Terminal-count cycle is dead time so segments never ghost across
        // the anode change.
        an_d   = '1;
        sseg_d = 8'hFF;
        if (!cnt_tc) begin
            for (int i = 0; i < N_DIGIT; i++) begin
                if (idx_q == IW'(i)) begin
                    an_d[i]     = 1'b0;
                    sseg_d[7]   = ~act_dp_q[i];
                    sseg_d[6:0] = (act_blank_q[i] || lz_blank[i]) ? 7'h7F
                                                                  : hex_to_seg(act_hex_q[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_hex_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            act_hex_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            sseg_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_hex_q     <= sh_hex_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            act_hex_q    <= act_hex_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_scan_mux.sv
module tb_led_scan_mux;

    localparam int N = 4;
    localparam int P = 4;
    localparam int F = N * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        pending;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    led_scan_mux #(.N_DIGIT(N), .PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .wr(wr), .hex_in(hex_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .an(an), .sseg(sseg),
        .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: scan position is just the number of edges since reset.
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_s;
    int          m_idx;
    logic [15:0] m_hex, m_sh_hex;
    logic [3:0]  m_dp, m_sh_dp, m_blank, m_sh_blank;
    logic        m_pend;
    logic [3:0]  exp_an;
    logic [7:0]  exp_sseg;
    logic        exp_pend, exp_ft;

    task automatic clear_model();
        m_s = 0; m_idx = 0;
        m_hex = '0; m_sh_hex = '0; m_dp = '0; m_sh_dp = '0;
        m_blank = '0; m_sh_blank = '0; m_pend = 1'b0;
    endtask

    // Computes the expected outputs for the coming edge, advances one clock,
    // updates the model and leaves time 1 unit past the edge.
    task automatic tick();
        int cnt;
        logic [3:0] nib;
        logic blk, commit;
        cnt    = m_s % P;
        m_idx  = (m_s / P) % N;
        exp_ft = ((m_s % F) == F - 1);
        if (cnt == P - 1) begin
            exp_an = 4'hF; exp_sseg = 8'hFF;
        end else begin
            exp_an   = ~(4'b0001 << m_idx);
            nib      = 4'(m_hex >> (4 * m_idx));
            blk      = m_blank[m_idx] || (lz_en && m_idx != 0 && (m_hex >> (4 * m_idx)) == 16'h0);
            exp_sseg = {~m_dp[m_idx], blk ? 7'h7F : seg_tab[nib]};
        end
        commit = exp_ft && m_pend;
        @(posedge clk);
        if (commit) begin
            m_hex = m_sh_hex; m_dp = m_sh_dp; m_blank = m_sh_blank;
        end
        if (wr) begin
            m_sh_hex = hex_in; m_sh_dp = dp_in; m_sh_blank = blank_in;
        end
        m_pend   = wr ? 1'b1 : (commit ? 1'b0 : m_pend);
        exp_pend = m_pend;
        m_s++;
        #1;
    endtask

    // Positions the scan so that the next tick() is the wrap edge.
    task automatic run_to_wrap();
        while ((m_s % F) != F - 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({an, sseg, pending, frame_tick} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got an=%h sseg=%h pend=%b ft=%b, want an=f sseg=ff pend=0 ft=0",
                     an, sseg, pending, frame_tick);
        end
        clear_model();
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int ft_count = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (frame_tick) ft_count++;
            n_tests++;
            if ({an, sseg, pending, frame_tick} !== {exp_an, exp_sseg, exp_pend, exp_ft}) begin
                n_fail++;
                $display("FAIL scan_c%0d: got an=%h sseg=%h pend=%b ft=%b, want an=%h sseg=%h pend=%b ft=%b",
                         k, an, sseg, pending, frame_tick, exp_an, exp_sseg, exp_pend, exp_ft);
            end
            if (an != 4'hF) begin
                n_tests++;
                if (sseg !== 8'hC0) begin
                    n_fail++;
                    $display("FAIL scan_zero_c%0d: got sseg=%h, want c0", k, sseg);
                end
            end
        end
        n_tests++;
        if (ft_count != 2) begin
            n_fail++;
            $display("FAIL scan_ft_count: got %0d pulses, want 2", ft_count);
        end
    endtask

    task automatic test_write();
        logic [7:0] want [4] = '{8'h88, 8'hB0, 8'h0E, 8'h80};
        while ((m_s % F) != 5) tick();
        wr = 1'b1; hex_in = 16'h8F3A; dp_in = 4'b0100; blank_in = 4'b0000;
        tick();
        wr = 1'b0;
        n_tests++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL write_pending: got %b, want 1", pending);
        end
        while ((m_s % F) != 0) begin
            tick();
            n_tests++;
            if ({an, sseg, pending, frame_tick} !== {exp_an, exp_sseg, exp_pend, exp_ft} ||
                (an != 4'hF && sseg !== 8'hC0)) begin
                n_fail++;
                $display("FAIL write_hold: got an=%h sseg=%h pend=%b ft=%b, want an=%h sseg=%h pend=%b ft=%b",
                         an, sseg, pending, frame_tick, exp_an, exp_sseg, exp_pend, exp_ft);
            end
        end
        for (int k = 0; k < F; k++) begin
            tick();
            n_tests++;
            if (an != 4'hF && (sseg !== want[m_idx] || pending !== 1'b0)) begin
                n_fail++;
                $display("FAIL write_digit%0d: got sseg=%h pend=%b, want sseg=%h pend=0",
                         m_idx, sseg, pending, want[m_idx]);
            end
        end
    endtask

    task automatic test_back_to_back();
        while ((m_s % F) != 2) tick();
        wr = 1'b1; hex_in = 16'h1111; dp_in = '0; blank_in = '0;
        tick();
        wr = 1'b0; tick(); tick();
        wr = 1'b1; hex_in = 16'h2222;
        tick();
        wr = 1'b0;
        run_to_wrap();
        wr = 1'b1; hex_in = 16'h3333;
        tick();
        wr = 1'b0;
        n_tests++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pending: got %b, want 1", pending);
        end
        for (int k = 0; k < 2 * F; k++) begin
            tick();
            n_tests++;
            if ({an, sseg, pending, frame_tick} !== {exp_an, exp_sseg, exp_pend, exp_ft} ||
                (an != 4'hF && sseg !== ((k < F) ? 8'hA4 : 8'hB0))) begin
                n_fail++;
                $display("FAIL b2b_frame_c%0d: got an=%h sseg=%h pend=%b, want an=%h sseg=%h pend=%b",
                         k, an, sseg, pending, exp_an, exp_sseg, exp_pend);
            end
        end
    endtask

    task automatic test_lz();
        logic [7:0] want_a [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        logic [7:0] want_b [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        lz_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            wr = 1'b1; hex_in = (pass == 0) ? 16'h0050 : 16'h0000; dp_in = '0; blank_in = '0;
            tick();
            wr = 1'b0;
            run_to_wrap();
            tick();
            for (int k = 0; k < F; k++) begin
                tick();
                n_tests++;
                if (an != 4'hF && sseg !== ((pass == 0) ? want_a[m_idx] : want_b[m_idx])) begin
                    n_fail++;
                    $display("FAIL lz_p%0d_digit%0d: got sseg=%h, want %h", pass, m_idx, sseg,
                             (pass == 0) ? want_a[m_idx] : want_b[m_idx]);
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blank();
        logic [7:0] want [4] = '{8'hF9, 8'h7F, 8'hB0, 8'h99};
        wr = 1'b1; hex_in = 16'h4321; dp_in = 4'b0010; blank_in = 4'b0010;
        tick();
        wr = 1'b0;
        run_to_wrap();
        tick();
        for (int k = 0; k < F; k++) begin
            tick();
            n_tests++;
            if (an != 4'hF && sseg !== want[m_idx]) begin
                n_fail++;
                $display("FAIL blank_digit%0d: got sseg=%h, want %h", m_idx, sseg, want[m_idx]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            wr = ($urandom_range(0, 7) == 0);
            hex_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) hex_in = hex_in & 16'h00FF;
            dp_in = 4'($urandom); blank_in = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            tick();
            n_tests++;
            if ({an, sseg, pending, frame_tick} !== {exp_an, exp_sseg, exp_pend, exp_ft}) begin
                n_fail++;
                $display("FAIL random_c%0d: got an=%h sseg=%h pend=%b ft=%b, want an=%h sseg=%h pend=%b ft=%b",
                         k, an, sseg, pending, frame_tick, exp_an, exp_sseg, exp_pend, exp_ft);
            end
        end
        wr = 1'b0; lz_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr = 1'b1; hex_in = 16'h1234; dp_in = 4'hF; blank_in = '0;
        tick();
        wr = 1'b0;
        while ((m_s % F) != 6) tick();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({an, sseg, pending, frame_tick} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got an=%h sseg=%h pend=%b ft=%b, want an=f sseg=ff pend=0 ft=0",
                     an, sseg, pending, frame_tick);
        end
        clear_model();
        reset = 1'b0;
        for (int k = 0; k < 2 * F; k++) begin
            tick();
            n_tests++;
            if ({an, sseg, pending, frame_tick} !== {exp_an, exp_sseg, exp_pend, exp_ft} ||
                (an != 4'hF && sseg !== 8'hC0)) begin
                n_fail++;
                $display("FAIL reset_after_c%0d: got an=%h sseg=%h pend=%b, want an=%h sseg=%h pend=%b",
                         k, an, sseg, pending, exp_an, exp_sseg, exp_pend);
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_scan();
        test_write();
        test_back_to_back();
        test_lz();
        test_blank();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
